// File: rtl/math_seq.sv
// rtl/math_seq.sv - two-requester round-robin sequencer computing a + b - c on one shared accumulator
// Optional signed overflow flag out_ovf when MATH_SEQ_OVF_EN is defined.
module math_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_a,
    input  logic [WIDTH-1:0] in0_b,
    input  logic [WIDTH-1:0] in0_c,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_a,
    input  logic [WIDTH-1:0] in1_b,
    input  logic [WIDTH-1:0] in1_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
`ifdef MATH_SEQ_OVF_EN
    output logic             out_ovf,
`endif
    output logic             out_id
);

    typedef enum logic [1:0] {IDLE, ADD, SUB, DONE} state_t;

    state_t           state, state_nxt;
    logic             prio;
    logic             id_q;
    logic [WIDTH-1:0] a_q, b_q, c_q, acc;
    logic [WIDTH-1:0] sum, diff;
    logic             grant_id;
    logic             accept;

    assign sum  = a_q + b_q;
    assign diff = acc - c_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_id  = prio;
        if (in0_valid && !in1_valid) begin
            grant_id = 1'b0;
        end else if (in1_valid && !in0_valid) begin
            grant_id = 1'b1;
        end
        // rst gates the readys so nothing looks accepted while reset is held
        in0_ready = (state == IDLE) && in0_valid && !grant_id && !rst;
        in1_ready = (state == IDLE) && in1_valid && grant_id && !rst;
        accept    = in0_ready || in1_ready;
        case (state)
            IDLE:    if (accept) state_nxt = ADD;
            ADD:     state_nxt = SUB;
            SUB:     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
            id_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            acc  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q  <= grant_id ? in1_a : in0_a;
                        b_q  <= grant_id ? in1_b : in0_b;
                        c_q  <= grant_id ? in1_c : in0_c;
                        id_q <= grant_id;
                        prio <= ~grant_id;
                    end
                end
                ADD:     acc <= sum;
                SUB:     acc <= diff;
                default: ;
            endcase
        end
    end

`ifdef MATH_SEQ_OVF_EN
    logic ovf_q;

    // Signed overflow: operands of like sign (add) or unlike sign (sub) yielding a sign flip
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (accept) ovf_q <= 1'b0;
                ADD:     ovf_q <= ovf_q | ((a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                           (sum[WIDTH-1] != a_q[WIDTH-1]));
                SUB:     ovf_q <= ovf_q | ((acc[WIDTH-1] != c_q[WIDTH-1]) &&
                                           (diff[WIDTH-1] != acc[WIDTH-1]));
                default: ;
            endcase
        end
    end

    assign out_ovf = ovf_q;
`endif

    assign out_valid = (state == DONE);
    assign out_z     = acc;
    assign out_id    = id_q;

endmodule

// File: tb/tb_math_seq.sv
// tb/tb_math_seq.sv - self-checking bench for math_seq against a transaction-level model
module tb_math_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in0_valid, in1_valid, out_ready;
    logic [15:0] in0_a, in0_b, in0_c, in1_a, in1_b, in1_c;
    logic        in0_ready, in1_ready, out_valid, out_id;
    logic [15:0] out_z;
`ifdef MATH_SEQ_OVF_EN
    logic        out_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    math_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in0_a(in0_a), .in0_b(in0_b), .in0_c(in0_c),
        .in1_valid(in1_valid), .in1_ready(in1_ready),
        .in1_a(in1_a), .in1_b(in1_b), .in1_c(in1_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z),
`ifdef MATH_SEQ_OVF_EN
        .out_ovf(out_ovf),
`endif
        .out_id(out_id)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Transaction model: busy flag, edges since accept, round-robin pointer, pending result
    bit          m_busy;
    int          m_cnt;
    bit          m_prio;
    bit          m_id;
    logic [15:0] m_z;
    bit          m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0;
            m_cnt  = 0;
            m_prio = 0;
        end else if (!m_busy) begin
            if (in0_valid || in1_valid) begin
                int sa, sb, sc, s1, s2;
                logic [15:0] a, b, c, w;
                m_id = (in0_valid && in1_valid) ? m_prio : in1_valid;
                a = m_id ? in1_a : in0_a;
                b = m_id ? in1_b : in0_b;
                c = m_id ? in1_c : in0_c;
                m_z = a + b - c;
                sa = int'($signed(a));
                sb = int'($signed(b));
                sc = int'($signed(c));
                s1 = sa + sb;
                w  = 16'(s1);
                s2 = int'($signed(w)) - sc;
                m_ovf  = (s1 > 32767) || (s1 < -32768) || (s2 > 32767) || (s2 < -32768);
                m_prio = !m_id;
                m_busy = 1;
                m_cnt  = 0;
            end
        end else if (m_cnt >= 2 && out_ready) begin
            m_busy = 0;
        end else if (m_cnt < 2) begin
            m_cnt++;
        end
    end

    always @(negedge clk) begin
        bit e_r0, e_r1, e_v;
        e_r0 = !rst && !m_busy && in0_valid && (!in1_valid || !m_prio);
        e_r1 = !rst && !m_busy && in1_valid && (!in0_valid || m_prio);
        e_v  = m_busy && (m_cnt >= 2);
        check("in0_ready", in0_ready, e_r0);
        check("in1_ready", in1_ready, e_r1);
        check("out_valid", out_valid, e_v);
        if (e_v) begin
            check("out_z", out_z, m_z);
            check("out_id", out_id, m_id);
`ifdef MATH_SEQ_OVF_EN
            check("out_ovf", out_ovf, m_ovf);
`endif
        end
    end

    logic [15:0] hs_z[$];
    bit          hs_id[$];
    int          hs_cyc[$];
    int          cyc = 0;

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_z.push_back(out_z);
            hs_id.push_back(out_id);
            hs_cyc.push_back(cyc);
        end
        cyc++;
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input bit p, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        int n;
        if (p) begin
            in1_a = a; in1_b = b; in1_c = c; in1_valid = 1'b1;
        end else begin
            in0_a = a; in0_b = b; in0_c = c; in0_valid = 1'b1;
        end
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            if ((!p && in0_ready) || (p && in1_ready)) break;
            n++;
        end
        check("send_timeout", n < 30, 1);
        @(posedge clk);
        #1;
        if (p) in1_valid = 1'b0;
        else   in0_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 1;
        while (n < 30) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        check("out_timeout", n < 30, 1);
    endtask

    initial begin
        int lat, hs_before;
        rst = 1'b1;
        in0_valid = 0; in1_valid = 0; out_ready = 1;
        in0_a = 0; in0_b = 0; in0_c = 0;
        in1_a = 0; in1_b = 0; in1_c = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_z", out_z, 0);
        check("rst_out_id", out_id, 0);

        // single requester, basic latency
        @(posedge clk); #1;
        send(0, 16'd10, 16'd20, 16'd5);
        wait_out(lat);
        check("latency", lat, 3);
        check("t1_z", out_z, 16'd25);
        check("t1_id", out_id, 0);
        @(posedge clk); #1;

        // both requesters continuously valid after reset
        do_reset();
        hs_z.delete(); hs_id.delete(); hs_cyc.delete();
        in0_a = 16'd7;   in0_b = 16'd8;  in0_c = 16'd1;
        in1_a = 16'd100; in1_b = 16'd50; in1_c = 16'd25;
        in0_valid = 1; in1_valid = 1;
        repeat (17) @(posedge clk);
        #1 in0_valid = 0; in1_valid = 0;
        repeat (6) @(posedge clk);
        #1;
        check("rr_count", hs_id.size() >= 4, 1);
        if (hs_id.size() >= 4) begin
            check("rr_id0", hs_id[0], 0);
            check("rr_id1", hs_id[1], 1);
            check("rr_id2", hs_id[2], 0);
            check("rr_id3", hs_id[3], 1);
            check("rr_z0", hs_z[0], 16'd14);
            check("rr_z1", hs_z[1], 16'd125);
            for (int i = 1; i < 4; i++) check("rr_spacing", hs_cyc[i] - hs_cyc[i-1], 4);
        end

        // modular wrap
        send(1, 16'hFFFF, 16'h0002, 16'h0003);
        wait_out(lat);
        check("wrap_z", out_z, 16'hFFFE);
        check("wrap_id", out_id, 1);
        @(posedge clk); #1;
`ifdef MATH_SEQ_OVF_EN
        send(0, 16'h7FFF, 16'h0001, 16'h0000);
        wait_out(lat);
        check("ovf_set", out_ovf, 1);
        check("ovf_set_z", out_z, 16'h8000);
        @(posedge clk); #1;
        send(0, 16'd5, 16'd3, 16'd2);
        wait_out(lat);
        check("ovf_clr", out_ovf, 0);
        check("ovf_clr_z", out_z, 16'd6);
        @(posedge clk); #1;
`endif

        // back-pressure with a competing requester waiting
        out_ready = 0;
        send(0, 16'h1234, 16'h0100, 16'h0034);
        in1_a = 16'd1; in1_b = 16'd1; in1_c = 16'd1; in1_valid = 1;
        wait_out(lat);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_z", out_z, 16'h1300);
            check("bp_id", out_id, 0);
            check("bp_r0", in0_ready, 0);
            check("bp_r1", in1_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1;
        @(negedge clk);
        check("bp_hold", out_valid, 1);
        @(negedge clk);
        check("bp_release", out_valid, 0);
        check("bp_next_ready", in1_ready, 1);
        @(posedge clk); #1 in1_valid = 0;
        wait_out(lat);
        check("bp_next_z", out_z, 16'd1);
        @(posedge clk); #1;

        // reset in the middle of an operation
        send(0, 16'd3, 16'd4, 16'd5);
        @(posedge clk); #1 rst = 1;
        hs_before = hs_id.size();
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_r0", in0_ready, 0);
        check("abort_r1", in1_ready, 0);
        @(posedge clk); #1 rst = 0;
        in0_a = 16'd2; in0_b = 16'd2; in0_c = 16'd1;
        in1_a = 16'd9; in1_b = 16'd9; in1_c = 16'd9;
        in0_valid = 1; in1_valid = 1;
        @(negedge clk);
        check("post_rst_r0", in0_ready, 1);
        check("post_rst_r1", in1_ready, 0);
        @(posedge clk); #1 in0_valid = 0; in1_valid = 0;
        check("no_abort_result", hs_id.size(), hs_before);
        wait_out(lat);
        check("post_rst_lat", lat, 3);
        check("post_rst_z", out_z, 16'd3);
        check("post_rst_id", out_id, 0);
        repeat (4) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/math_seq.md
# math_seq

Multi-cycle controller that shares one WIDTH-bit add/subtract datapath between two requesters to compute Z = A + B − C. It sits in front of the arithmetic unit and arbitrates round-robin between two operand sources. It sequences the add step and then the subtract step through a single shared accumulator, and returns the tagged result over a valid/ready handshake.

## Interface
- WIDTH, 16, operand/result width in bits

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in0_valid  input  1  requester 0 has operands
- in0_ready  output  1  requester 0 operands accepted this cycle
- in0_a, in0_b, in0_c  input  WIDTH each  requester 0 operands
- in1_valid  input  1  requester 1 has operands
- in1_ready  output  1  requester 1 operands accepted this cycle
- in1_a, in1_b, in1_c  input  WIDTH each  requester 1 operands
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_z  output  WIDTH  A + B − C, modulo 2^WIDTH
- out_id  output  1  requester that issued the result
- out_ovf  output  1  signed overflow flag (present only with MATH_SEQ_OVF_EN)

## Operation
- States: IDLE, ADD, SUB, DONE. Reset state is IDLE.
- Reset values:
  - in0_ready = in1_ready = 0
  - out_valid = 0, out_z = 0, out_id = 0, out_ovf = 0
  - priority pointer prio = 0
  - operand registers and accumulator = 0
- Grant (combinational, IDLE only):
  - only in0_valid → grant 0
  - only in1_valid → grant 1
  - both valid → grant prio
  - inX_ready = (state == IDLE) & grantX
  - Both readys are 0 outside IDLE.
- Accept (IDLE, valid & ready):
  - register the granted requester's a, b, c and its id
  - prio ← ~id
  - go to ADD
- ADD: acc ← a + b; go to SUB.
- SUB: acc ← acc − c; go to DONE.
- DONE:
  - out_valid = 1
  - out_z = acc and out_id = id; both held stable while out_valid = 1 and out_ready = 0
  - out_valid & out_ready → IDLE
- Arithmetic: unsigned modulo 2^WIDTH; carry and borrow are discarded.
- Operands change on an un-granted port: ignored.
- Valid deasserted before grant: no effect. Requesters must hold valid and operands until ready.
- rst mid-operation: operation discarded, all state returns to reset values immediately, no result is emitted.

## Timing
- Accept at rising edge k: state ADD after k, SUB after k+1, DONE after k+2.
- out_valid is high from edge k+2 onward.
- Latency: 2 cycles from accept edge to out_valid.
- Result handshake at edge m → IDLE after m. Earliest next accept is at edge m+1.
- Throughput with out_ready tied high: one result per 4 cycles.
- No combinational path from in*_valid to out_*. in*_ready depends combinationally on in*_valid, state and prio.

## Configuration
- MATH_SEQ_OVF_EN defined:
  - out_ovf port exists
  - operands are treated as two's complement
  - out_ovf = 1 if the add step or the subtract step overflowed signed range (sticky across the two steps of one operation)
  - out_ovf is cleared on accept
  - out_ovf is valid with out_valid
- Not defined: out_ovf port and its logic are absent; everything else is identical.

## Test plan
- WIDTH=16, only in0: a=10, b=20, c=5 at accept edge k → out_valid at k+2, out_z=25, out_id=0; in0_ready=0 during ADD/SUB/DONE.
- Both valid every cycle, out_ready=1 → grants alternate 0,1,0,1 starting with 0 after reset; four results with ids 0,1,0,1, one every 4 cycles.
- Wrap: a=0xFFFF, b=0x0002, c=0x0003 → out_z=0xFFFE. With MATH_SEQ_OVF_EN: a=0x7FFF, b=1, c=0 → out_ovf=1; a=5, b=3, c=2 → out_ovf=0.
- Back-pressure: out_ready=0 for 5 cycles in DONE → out_valid, out_z, out_id stable, both readys 0; out_ready=1 → IDLE next edge.
- rst asserted during SUB → out_valid=0, state IDLE, prio=0 immediately; no result for the aborted operation; the next accept behaves as after power-up.
